fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue_storage.sv | 23 ++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions: opcode constants, the fetch-queue entry layout and
// the default bubble instruction.
package fetch_queue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // sll $0,$0,0 -- the canonical bubble
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  localparam int FETCH_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } fetchEntryT;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one synchronous write port, one
// asynchronous read port, no reset.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// Fall-through circular FIFO between fetch and decode; decouples the fetch
// enable from decode stalls and drops everything on a control-flow redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc_plus_4,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc_plus_4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] occupancy;
  logic          doPush;
  logic          doPop;
  fetchEntryT    wrEntry;
  fetchEntryT    headEntry;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Handshakes depend only on registered occupancy, never on the other side.
  assign in_ready  = (occupancy != FULL_COUNT);
  assign out_valid = (occupancy != '0);
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;
  assign count     = occupancy;

  assign wrEntry = '{instr: in_instr, pcPlus4: in_pc_plus_4};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      occupancy <= '0;
    end else if (flush) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  fq_storage #(
    .DEPTH(DEPTH),
    .WIDTH(FETCH_ENTRY_W)
  ) u_storage (
    .clk    (clk),
    .wrEn   (doPush && !flush),
    .wrAddr (wrPtr),
    .wrData (wrEntry),
    .rdAddr (rdPtr),
    .rdData (headEntry)
  );

  // Stale storage is masked so an empty queue always presents a bubble.
  always_comb begin
    out_instr     = NOP_WORD;
    out_pc_plus_4 = '0;
    if (out_valid) begin
      out_instr     = headEntry.instr;
      out_pc_plus_4 = headEntry.pcPlus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against a queue scoreboard.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [31:0]            in_instr;
  logic [31:0]            in_pc_plus_4;
  logic                   in_ready;
  logic                   flush;
  logic                   out_ready;
  logic                   out_valid;
  logic [31:0]            out_instr;
  logic [31:0]            out_pc_plus_4;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic [31:0] popLog[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc_plus_4 (out_pc_plus_4),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutputs();
    logic [31:0] eI;
    logic [31:0] eP;
    eI = NOP;
    eP = 32'h0;
    if (mq.size() != 0) begin
      eI = mq[0][63:32];
      eP = mq[0][31:0];
    end
    chk("count",     32'(count),     32'(mq.size()));
    chk("inReady",   32'(in_ready),  32'(mq.size() != DEPTH));
    chk("outValid",  32'(out_valid), 32'(mq.size() != 0));
    chk("outInstr",  out_instr,      eI);
    chk("outPc",     out_pc_plus_4,  eP);
    chk("countMax",  32'(count <= DEPTH), 32'd1);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    logic doPush;
    logic doPop;
    in_valid     = v;
    in_instr     = ins;
    in_pc_plus_4 = pc;
    flush        = fl;
    out_ready    = ordy;
    #1;
    checkOutputs();
    doPush = v && (mq.size() < DEPTH);
    doPop  = ordy && (mq.size() != 0);
    if (doPop && !fl) popLog.push_back(out_instr);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (doPop)  void'(mq.pop_front());
      if (doPush) mq.push_back({ins, pc});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic popOne();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    cycle(1'b1, ins, pc, 1'b0, 1'b0);
  endtask

  task automatic chkPop(input string tag, input logic [31:0] expected);
    logic [31:0] got;
    got = 32'hxxxx_xxxx;
    if (popLog.size() != 0) got = popLog.pop_front();
    chk(tag, got, expected);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc_plus_4 = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rstCount",    32'(count),     32'd0);
    chk("rstInReady",  32'(in_ready),  32'd1);
    chk("rstOutValid", 32'(out_valid), 32'd0);
    chk("rstInstr",    out_instr,      NOP);
    chk("rstPc",       out_pc_plus_4,  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // fill
    push(32'h2008_0005, 32'h4);
    push(32'h2009_0003, 32'h8);
    push(32'h0109_5020, 32'hC);
    push(32'hAC0A_0000, 32'h10);
    #1;
    chk("fillCount",   32'(count),    32'd4);
    chk("fillInReady", 32'(in_ready), 32'd0);
    chk("fillInstr",   out_instr,     32'h2008_0005);
    chk("fillPc",      out_pc_plus_4, 32'h4);
    cycle(1'b1, 32'hDEAD_BEEF, 32'h99, 1'b0, 1'b0);
    #1;
    chk("fullNoPush",  32'(count),    32'd4);
    chk("fullHead",    out_instr,     32'h2008_0005);

    // drain with wrap
    popOne();
    popOne();
    push(32'h1100_0002, 32'h14);
    push(32'h0800_0000, 32'h18);
    popLog.delete();
    repeat (4) popOne();
    chk("popSize", 32'(popLog.size()), 32'd4);
    chkPop("pop0", 32'h0109_5020);
    chkPop("pop1", 32'hAC0A_0000);
    chkPop("pop2", 32'h1100_0002);
    chkPop("pop3", 32'h0800_0000);
    #1;
    chk("drainValid", 32'(out_valid), 32'd0);
    chk("drainInstr", out_instr,      32'h0);
    popOne();
    #1;
    chk("emptyPopCount", 32'(count), 32'd0);
    chk("emptyPopInstr", out_instr,  NOP);

    // simultaneous push and pop
    push(32'hA000_0001, 32'h20);
    push(32'hA000_0002, 32'h24);
    popLog.delete();
    cycle(1'b1, 32'hA000_0003, 32'h28, 1'b0, 1'b1);
    #1;
    chk("simulCount", 32'(count), 32'd2);
    popOne();
    popOne();
    chkPop("simul0", 32'hA000_0001);
    chkPop("simul1", 32'hA000_0002);
    chkPop("simul2", 32'hA000_0003);

    // flush with push and pop pending
    push(32'hB000_0001, 32'h30);
    push(32'hB000_0002, 32'h34);
    push(32'hB000_0003, 32'h38);
    cycle(1'b1, 32'hB000_0004, 32'h3C, 1'b1, 1'b1);
    #1;
    chk("flushCount", 32'(count),     32'd0);
    chk("flushValid", 32'(out_valid), 32'd0);
    push(32'hC000_0001, 32'h100);
    #1;
    chk("afterFlushValid", 32'(out_valid), 32'd1);
    chk("afterFlushInstr", out_instr,      32'hC000_0001);
    chk("afterFlushPc",    out_pc_plus_4,  32'h100);

    // asynchronous reset mid-cycle at count=3
    push(32'hD000_0001, 32'h200);
    push(32'hD000_0002, 32'h204);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("preRstCount", 32'(count), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("asyncRstCount",   32'(count),     32'd0);
    chk("asyncRstInstr",   out_instr,      32'h0);
    chk("asyncRstValid",   32'(out_valid), 32'd0);
    chk("asyncRstInReady", 32'(in_ready),  32'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    push(32'hE000_0001, 32'h300);
    #1;
    chk("resumeInstr", out_instr, 32'hE000_0001);
    idle();

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
